// File: rtl/lock_err_pkg.sv
// Shared types and helpers for locked-adder output monitors.
// Provides the window FSM states, Hamming-distance width, popcount and saturating add.
package lock_err_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    // Widest vector popcount() accepts; callers zero-extend into it.
    localparam int POP_MAX_W = 128;

    // Bits needed to hold a Hamming distance of 0..width+1.
    function automatic int hd_width(input int width);
        return $clog2(width + 2);
    endfunction

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

    // a + b clamped to 2^w - 1, for counters up to 64 bits wide.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int w);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        if (sum > lim) begin
            return lim[63:0];
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/lock_err_monitor_if.sv
// Sample/command/report bundle between a locked-adder harness and lock_err_monitor.
// The monitor uses the slave modport; the harness driving samples uses master.
interface lock_err_monitor_if
    import lock_err_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
);
    localparam int HD_W = hd_width(WIDTH);

    logic             clear_i;
    logic             close_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] add1_i;
    logic [WIDTH-1:0] add2_i;
    logic [WIDTH:0]   result_i;
    logic             busy_o;
    logic             rpt_valid_o;
    logic [CNT_W-1:0] rpt_samples_o;
    logic [CNT_W-1:0] rpt_mismatch_o;
    logic [CNT_W-1:0] rpt_biterr_o;
    logic [HD_W-1:0]  rpt_maxhd_o;

    modport master (
        output clear_i, close_i, in_valid_i, add1_i, add2_i, result_i,
        input  in_ready_o, busy_o, rpt_valid_o, rpt_samples_o, rpt_mismatch_o,
               rpt_biterr_o, rpt_maxhd_o
    );

    modport slave (
        input  clear_i, close_i, in_valid_i, add1_i, add2_i, result_i,
        output in_ready_o, busy_o, rpt_valid_o, rpt_samples_o, rpt_mismatch_o,
               rpt_biterr_o, rpt_maxhd_o
    );

endinterface

// File: rtl/loa_golden_model.sv
// Unlocked lower-part-OR adder: low LOWER_W bits are ORed, the upper part is a
// true add whose carry-in is the AND of the top lower-part operand bits.
module loa_golden_model #(
    parameter int WIDTH   = 32,
    parameter int LOWER_W = 8
) (
    input  logic [WIDTH-1:0] add1,
    input  logic [WIDTH-1:0] add2,
    output logic [WIDTH:0]   golden
);
    localparam int UW = WIDTH - LOWER_W;

    logic          cin;
    logic [UW:0]   upper;

    assign cin    = add1[LOWER_W-1] & add2[LOWER_W-1];
    assign upper  = {1'b0, add1[WIDTH-1:LOWER_W]} + {1'b0, add2[WIDTH-1:LOWER_W]}
                  + {{UW{1'b0}}, cin};
    assign golden = {upper, add1[LOWER_W-1:0] | add2[LOWER_W-1:0]};

endmodule

// File: rtl/lock_err_monitor.sv
// Windowed corruption statistics for a key-locked lower-part-OR adder.
//   state     | meaning
//   ST_IDLE   | no window open; last report fields held
//   ST_RUN    | accepting samples, one per cycle
//   ST_DRAIN  | no new samples; waiting for S1/S2 to empty
//   ST_REPORT | one-cycle rpt_valid_o pulse
module lock_err_monitor
    import lock_err_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LOWER_W = 8,
    parameter int CNT_W   = 32
) (
    input logic              clk,
    input logic              rst_n,
    lock_err_monitor_if.slave bus
);
    localparam int HD_W = hd_width(WIDTH);

    state_t           state_q, state_d;
    logic             in_ready, busy, rpt_valid, win_clear, accept;

    logic             s1_valid, s2_valid;
    logic [WIDTH:0]   s1_result, s1_golden, golden_c;
    logic [HD_W-1:0]  s2_hd;
    logic             s2_mm;

    logic [CNT_W-1:0] samples_q, mismatch_q, biterr_q;
    logic [HD_W-1:0]  maxhd_q;

    loa_golden_model #(.WIDTH(WIDTH), .LOWER_W(LOWER_W)) u_golden (
        .add1   (bus.add1_i),
        .add2   (bus.add2_i),
        .golden (golden_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Clear has priority over close in RUN; both are ignored once draining.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        rpt_valid = 1'b0;
        win_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.clear_i) begin
                    state_d   = ST_RUN;
                    win_clear = 1'b1;
                end
            end
            ST_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (bus.clear_i)      win_clear = 1'b1;
                else if (bus.close_i) state_d   = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                // S1 cannot refill here, so S2 retires at this edge when S1 is empty.
                if (!s1_valid) state_d = ST_REPORT;
            end
            ST_REPORT: begin
                rpt_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept = bus.in_valid_i & in_ready & ~win_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s1_result <= '0;
            s1_golden <= '0;
            s2_hd     <= '0;
            s2_mm     <= 1'b0;
        end else begin
            if (win_clear) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                s1_valid <= accept;
                s2_valid <= s1_valid;
            end
            if (accept) begin
                s1_result <= bus.result_i;
                s1_golden <= golden_c;
            end
            if (s1_valid) begin
                s2_hd <= HD_W'(popcount(POP_MAX_W'(s1_result ^ s1_golden)));
                s2_mm <= (s1_result != s1_golden);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samples_q  <= '0;
            mismatch_q <= '0;
            biterr_q   <= '0;
            maxhd_q    <= '0;
        end else if (win_clear) begin
            samples_q  <= '0;
            mismatch_q <= '0;
            biterr_q   <= '0;
            maxhd_q    <= '0;
        end else if (s2_valid) begin
            samples_q  <= CNT_W'(sat_add(64'(samples_q), 64'd1, CNT_W));
            mismatch_q <= CNT_W'(sat_add(64'(mismatch_q), 64'(s2_mm), CNT_W));
            biterr_q   <= CNT_W'(sat_add(64'(biterr_q), 64'(s2_hd), CNT_W));
            if (s2_hd > maxhd_q) maxhd_q <= s2_hd;
        end
    end

    assign bus.in_ready_o     = in_ready;
    assign bus.busy_o         = busy;
    assign bus.rpt_valid_o    = rpt_valid;
    assign bus.rpt_samples_o  = samples_q;
    assign bus.rpt_mismatch_o = mismatch_q;
    assign bus.rpt_biterr_o   = biterr_q;
    assign bus.rpt_maxhd_o    = maxhd_q;

endmodule

// File: tb/tb_lock_err_monitor.sv
// Scoreboard bench: two monitors (32-bit and 4-bit counters) driven with identical windows.
module tb_lock_err_monitor;

    typedef struct {
        longint s;
        longint m;
        longint b;
        longint h;
        int     due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q32[$];
    exp_t q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lock_err_monitor_if #(.WIDTH(32), .CNT_W(32)) if32();
    lock_err_monitor_if #(.WIDTH(32), .CNT_W(4))  if4();

    lock_err_monitor #(.WIDTH(32), .LOWER_W(8), .CNT_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .bus(if32));
    lock_err_monitor #(.WIDTH(32), .LOWER_W(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4));

    // Hand-computed golden values with LOWER_W = 8.
    localparam logic [31:0] A_A = 32'h12345678, A_B = 32'h11111111;
    localparam logic [32:0] A_G = 33'h023456779, A_BAD = 33'h02345677A;  // hd 2
    localparam logic [31:0] F_A = 32'hFFFFFFFF;
    localparam logic [32:0] F_G = 33'h1FFFFFFFF;
    localparam logic [31:0] C_A = 32'h00000080;
    localparam logic [32:0] C_G = 33'h000000180;
    localparam logic [31:0] E_A = 32'h000000FF, E_B = 32'h00000001;
    localparam logic [32:0] E_R = 33'h000000100;                         // golden 0x0FF, hd 9

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic longint sat4(input longint v);
        return (v > 15) ? 64'd15 : v;
    endfunction

    task automatic push_exp(input longint s, input longint m, input longint b,
                            input longint h, input int lat);
        exp_t e;
        e.s = s; e.m = m; e.b = b; e.h = h;
        e.due = cyc + 1 + lat;
        q32.push_back(e);
        q4.push_back(e);
    endtask

    task automatic tick(input logic c, input logic cl, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic [32:0] r);
        if32.clear_i = c;  if32.close_i = cl; if32.in_valid_i = v;
        if32.add1_i  = a;  if32.add2_i  = b;  if32.result_i   = r;
        if4.clear_i  = c;  if4.close_i  = cl; if4.in_valid_i  = v;
        if4.add1_i   = a;  if4.add2_i   = b;  if4.result_i    = r;
        @(posedge clk);
        #1;
        if32.clear_i = 1'b0; if32.close_i = 1'b0; if32.in_valid_i = 1'b0;
        if4.clear_i  = 1'b0; if4.close_i  = 1'b0; if4.in_valid_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, '0, '0, '0);
    endtask

    task automatic chk_pending(input string nm);
        chk({nm, "_pending32"}, q32.size(), 0);
        chk({nm, "_pending4"}, q4.size(), 0);
        q32.delete();
        q4.delete();
    endtask

    always @(negedge clk) begin
        if (if32.rpt_valid_o) begin
            if (q32.size() == 0) begin
                chk("rpt32_unexpected_queue", q32.size(), 1);
            end else begin
                exp_t e;
                e = q32.pop_front();
                chk("rpt32_samples",  if32.rpt_samples_o,  e.s);
                chk("rpt32_mismatch", if32.rpt_mismatch_o, e.m);
                chk("rpt32_biterr",   if32.rpt_biterr_o,   e.b);
                chk("rpt32_maxhd",    if32.rpt_maxhd_o,    e.h);
                chk("rpt32_cycle",    cyc,                 e.due);
            end
        end
    end

    always @(negedge clk) begin
        if (if4.rpt_valid_o) begin
            if (q4.size() == 0) begin
                chk("rpt4_unexpected_queue", q4.size(), 1);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("rpt4_samples",  if4.rpt_samples_o,  sat4(e.s));
                chk("rpt4_mismatch", if4.rpt_mismatch_o, sat4(e.m));
                chk("rpt4_biterr",   if4.rpt_biterr_o,   sat4(e.b));
                chk("rpt4_maxhd",    if4.rpt_maxhd_o,    e.h);
                chk("rpt4_cycle",    cyc,                e.due);
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        if32.clear_i = 0; if32.close_i = 0; if32.in_valid_i = 0;
        if32.add1_i = '0; if32.add2_i = '0; if32.result_i = '0;
        if4.clear_i = 0;  if4.close_i = 0;  if4.in_valid_i = 0;
        if4.add1_i = '0;  if4.add2_i = '0;  if4.result_i = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", if32.in_ready_o, 0);
        chk("rst_busy", if32.busy_o, 0);
        chk("rst_rpt_valid", if32.rpt_valid_o, 0);
        chk("rst_samples", if32.rpt_samples_o, 0);
        chk("rst_biterr", if32.rpt_biterr_o, 0);
        chk("rst_maxhd", if32.rpt_maxhd_o, 0);
        chk("rst4_busy", if4.busy_o, 0);
        rst_n = 1'b1;
        idle(2);
        chk("idle_in_ready", if32.in_ready_o, 0);

        // W1: four matching samples, close with the last one
        tick(1, 0, 0, '0, '0, '0);
        chk("clear_busy", if32.busy_o, 1);
        chk("clear_in_ready", if32.in_ready_o, 1);
        tick(0, 0, 1, A_A, A_B, A_G);
        tick(0, 0, 1, '0, '0, '0);
        tick(0, 0, 1, F_A, F_A, F_G);
        push_exp(4, 0, 0, 0, 2);
        tick(0, 1, 1, C_A, C_A, C_G);
        chk("drain_in_ready", if32.in_ready_o, 0);
        chk("drain_busy", if32.busy_o, 1);
        for (int i = 0; i < 4; i++) tick(0, 0, 1, E_A, E_B, E_R);
        idle(3);
        chk_pending("w1");

        // W2: two corrupted samples, close on an empty pipeline
        tick(1, 0, 0, '0, '0, '0);
        tick(0, 0, 1, E_A, E_B, E_R);
        tick(0, 0, 1, A_A, A_B, A_BAD);
        idle(4);
        push_exp(2, 2, 11, 9, 1);
        tick(0, 1, 0, '0, '0, '0);
        idle(5);
        chk_pending("w2");

        // W3: clear mid-window flushes in-flight samples and the clear-cycle sample
        tick(1, 0, 0, '0, '0, '0);
        tick(0, 0, 1, E_A, E_B, E_R);
        tick(0, 0, 1, E_A, E_B, E_R);
        tick(1, 0, 1, E_A, E_B, E_R);
        push_exp(1, 0, 0, 0, 2);
        tick(0, 1, 1, A_A, A_B, A_G);
        idle(5);
        chk_pending("w3");

        // W4: clear together with close restarts the window, no report
        tick(1, 0, 0, '0, '0, '0);
        tick(0, 0, 1, E_A, E_B, E_R);
        tick(0, 0, 1, E_A, E_B, E_R);
        tick(1, 1, 0, '0, '0, '0);
        chk("clrclose_busy", if32.busy_o, 1);
        chk("clrclose_in_ready", if32.in_ready_o, 1);
        idle(4);
        chk("clrclose_samples", if32.rpt_samples_o, 0);
        chk("clrclose_biterr", if32.rpt_biterr_o, 0);
        chk("clrclose_busy_after", if32.busy_o, 1);
        push_exp(1, 0, 0, 0, 2);
        tick(0, 1, 1, F_A, F_A, F_G);
        idle(5);
        chk_pending("w4");
        chk("idle_hold_samples", if32.rpt_samples_o, 1);

        // W5: 20 corrupted samples, 4-bit counters saturate
        tick(1, 0, 0, '0, '0, '0);
        for (int i = 0; i < 19; i++) tick(0, 0, 1, E_A, E_B, E_R);
        push_exp(20, 20, 180, 9, 2);
        tick(0, 1, 1, E_A, E_B, E_R);
        idle(5);
        chk_pending("w5");

        // W6: reset while draining, no report and fields cleared
        tick(1, 0, 0, '0, '0, '0);
        tick(0, 0, 1, E_A, E_B, E_R);
        tick(0, 1, 1, E_A, E_B, E_R);
        chk("pre_rst_busy", if32.busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", if32.busy_o, 0);
        chk("mid_rst_rpt_valid", if32.rpt_valid_o, 0);
        chk("mid_rst_samples", if32.rpt_samples_o, 0);
        chk("mid_rst_mismatch", if32.rpt_mismatch_o, 0);
        chk("mid_rst_biterr", if32.rpt_biterr_o, 0);
        chk("mid_rst_maxhd", if32.rpt_maxhd_o, 0);
        chk("mid_rst4_samples", if4.rpt_samples_o, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(6);
        chk("post_rst_samples", if32.rpt_samples_o, 0);
        chk_pending("w6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lock_err_monitor.md
# lock_err_monitor

Output-corruption monitor that sits directly downstream of the key-locked 32-bit lower-part-OR carry-lookahead adder. It accepts each applied operand pair together with the locked adder's 33-bit result, recomputes the unlocked lower-part-OR result internally, and accumulates per-window statistics: samples, mismatching samples, total bit errors (Hamming distance) and worst-case Hamming distance. A window is bracketed by clear/close commands, one window per applied key, and ends with a one-cycle report.

## Interface
- WIDTH, 32: operand width; result width is WIDTH+1.
- LOWER_W, 8: number of low bits computed by OR in the approximate adder (1 ≤ LOWER_W < WIDTH).
- CNT_W, 32: width of all accumulation counters.
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear_i  in  1  start a new window: zero counters, enter RUN.
- close_i  in  1  end the current window: drain, then report.
- in_valid_i  in  1  sample present.
- in_ready_o  out  1  sample accepted when in_valid_i && in_ready_o.
- add1_i  in  WIDTH  operand A as applied to the locked adder.
- add2_i  in  WIDTH  operand B.
- result_i  in  WIDTH+1  locked adder output for this operand pair.
- busy_o  out  1  high in RUN and DRAIN.
- rpt_valid_o  out  1  one-cycle pulse; report fields valid.
- rpt_samples_o  out  CNT_W  accepted samples in window.
- rpt_mismatch_o  out  CNT_W  samples with result_i ≠ golden.
- rpt_biterr_o  out  CNT_W  sum of popcount(result_i ^ golden).
- rpt_maxhd_o  out  $clog2(WIDTH+2)  maximum per-sample Hamming distance.

## Operation
- Golden: upper = add1_i[WIDTH-1:LOWER_W] + add2_i[WIDTH-1:LOWER_W] + (add1_i[LOWER_W-1] & add2_i[LOWER_W-1]), WIDTH-LOWER_W+1 bits; golden = {upper, add1_i[LOWER_W-1:0] | add2_i[LOWER_W-1:0]}.
- FSM states: IDLE, RUN, DRAIN, REPORT.
- IDLE: in_ready_o=0; clear_i → RUN, counters and max zeroed, report fields zeroed.
- RUN: in_ready_o=1. close_i → DRAIN. clear_i → RUN with counters zeroed and pipeline flushed (in-flight samples discarded; sample accepted in the clear cycle is discarded too). clear_i and close_i together: clear wins, close ignored.
- DRAIN: in_ready_o=0; stays until both pipeline stages are empty → REPORT.
- REPORT: rpt_valid_o=1 for exactly this cycle → IDLE. Report fields hold their values in IDLE until the next clear_i.
- clear_i/close_i in IDLE (close), DRAIN, REPORT: ignored.
- Pipeline: S1 registers operands, result_i, golden; S2 registers hd = popcount(result_i ^ golden) and mismatch flag; S3 updates accumulators.
- Counters saturate at 2^CNT_W−1 (no wrap); each counter saturates independently.
- A sample accepted in the same cycle close_i is sampled is counted.

## Timing
- Reset (async assert, sync-effective deassert): state IDLE, in_ready_o=0, busy_o=0, rpt_valid_o=0, all rpt_* and counters 0, pipeline valids 0.
- Sample accepted at edge t: in S1 after t, S2 after t+1, accumulators updated at edge t+2.
- Throughput: one sample per cycle in RUN; no internal stalls.
- close_i at edge t with continuous traffic: DRAIN for cycles t+1..t+2, REPORT at t+3 (rpt_valid_o high), IDLE at t+4. Empty pipeline at close: REPORT follows one DRAIN cycle.
- rst_n low mid-window: immediate return to reset values, no report pulse.

## Structure
- Package lock_err_pkg: state enum, HD_W = $clog2(WIDTH+2) helper, saturating-increment function.
- Sub-module loa_golden_model (combinational, WIDTH/LOWER_W parameters): operands in, WIDTH+1 golden out; reused by other locked-adder monitors.
- Popcount as a function in the package; top holds FSM, pipeline, accumulators.

## Test plan
- Reset: rst_n low → all outputs 0, in_ready_o=0; release, clear_i → busy_o=1, in_ready_o=1 next cycle.
- Four samples with result_i = golden (e.g. 0x12345678+0x11111111 → 0x023456779? use model), close → rpt_samples_o=4, mismatch=0, biterr=0, maxhd=0, rpt_valid_o one cycle at close+3.
- add1=0x000000FF, add2=0x00000001, result_i=0x100 (exact sum) → golden 0x0FF, hd 9 → mismatch=1, biterr=9, maxhd=9.
- Back-to-back samples, close_i in same cycle as last accepted sample → that sample counted; in_valid_i held during DRAIN not accepted, not counted.
- CNT_W=4, 20 mismatching samples → rpt_samples_o=15, rpt_mismatch_o=15 (saturated).
- rst_n asserted in DRAIN → no rpt_valid_o, rpt_* = 0; clear_i together with close_i in RUN → window restarts, counters 0, no report.
